// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor for the ALU datapath: one carry-chained
// slice per stage, valid/ready handshake with bubble collapsing, flags from the last stage.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg
);

   localparam int SW  = WIDTH / STAGES;
   localparam int MSB = WIDTH - 1;

   logic [STAGES-1:0] r_valid;
   logic [WIDTH-1:0]  r_a     [STAGES];
   logic [WIDTH-1:0]  r_b     [STAGES];   // holds b_eff: already inverted for subtract
   logic [WIDTH-1:0]  r_sum   [STAGES];
   logic              r_carry [STAGES];

   logic [STAGES-1:0] w_free;
   logic              w_v_up    [STAGES];
   logic [WIDTH-1:0]  w_a_up    [STAGES];
   logic [WIDTH-1:0]  w_b_up    [STAGES];
   logic [WIDTH-1:0]  w_s_up    [STAGES];
   logic              w_c_up    [STAGES];
   logic [WIDTH-1:0]  w_sum_nxt [STAGES];
   logic              w_c_nxt   [STAGES];

   // A stage may load when it is empty or its content moves on this cycle.
   always_comb begin
      w_free[STAGES-1] = !r_valid[STAGES-1] || out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         w_free[k] = !r_valid[k] || w_free[k+1];
      end
   end

   assign in_ready = w_free[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SW:0]      w_slice;
      logic [WIDTH-1:0] w_sum;

      if (k == 0) begin : g_first
         assign w_v_up[k] = in_valid;
         assign w_a_up[k] = in_a;
         assign w_b_up[k] = in_sub ? ~in_b : in_b;
         assign w_c_up[k] = in_cin ^ in_sub;
         assign w_s_up[k] = '0;
      end else begin : g_next
         assign w_v_up[k] = r_valid[k-1];
         assign w_a_up[k] = r_a[k-1];
         assign w_b_up[k] = r_b[k-1];
         assign w_c_up[k] = r_carry[k-1];
         assign w_s_up[k] = r_sum[k-1];
      end

      assign w_slice = {1'b0, w_a_up[k][k*SW +: SW]}
                     + {1'b0, w_b_up[k][k*SW +: SW]}
                     + {{SW{1'b0}}, w_c_up[k]};

      // NOTE: w_sum takes a full default before the slice overwrite, so no latch is inferred.
      always_comb begin
         w_sum              = w_s_up[k];
         w_sum[k*SW +: SW]  = w_slice[SW-1:0];
      end

      assign w_sum_nxt[k] = w_sum;
      assign w_c_nxt[k]   = w_slice[SW];
   end

   // NOTE: the datapath registers are reset as well as the valid bits, so out_sum reads 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]     <= '0;
            r_b[k]     <= '0;
            r_sum[k]   <= '0;
            r_carry[k] <= 1'b0;
         end
      end else begin
         // NOTE: non-blocking assignments make every stage sample its upstream neighbour's old value.
         for (int k = 0; k < STAGES; k++) begin
            if (w_free[k]) begin
               r_valid[k] <= w_v_up[k];
               if (w_v_up[k]) begin
                  r_a[k]     <= w_a_up[k];
                  r_b[k]     <= w_b_up[k];
                  r_sum[k]   <= w_sum_nxt[k];
                  r_carry[k] <= w_c_nxt[k];
               end
            end
         end
      end
   end

   assign out_valid = r_valid[STAGES-1];
   assign out_sum   = r_sum[STAGES-1];
   assign out_cout  = r_carry[STAGES-1];
   assign out_ovf   = (r_a[STAGES-1][MSB] == r_b[STAGES-1][MSB])
                   && (out_sum[MSB] != r_a[STAGES-1][MSB]);
   assign out_zero  = (out_sum == '0);
   assign out_neg   = out_sum[MSB];

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined integer adder/subtractor for the KGP-miniRISC ALU datapath; next generation of the fixed-width 32-bit carry-lookahead adder.
- Splits a WIDTH-bit add/sub into STAGES equal carry-chained slices, one slice per pipeline stage, with a valid/ready handshake and backpressure.
- Produces result plus carry, signed overflow, zero and negative flags for the ALU flag register.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, pipeline depth and slice count; 1..8. Slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in (add) / borrow-in (sub).
- in_sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry-out of MSB (carry, not borrow, for sub).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.
- out_neg  output  1  out_sum[WIDTH-1].

Behaviour:
- Arithmetic:
  - b_eff = in_sub ? ~in_b : in_b.
  - c_eff = in_sub ? ~in_cin : in_cin.
  - {out_cout, out_sum} = in_a + b_eff + c_eff, modulo 2^(WIDTH+1).
  - Sub therefore computes A − B − cin. out_cout = 1 means no borrow.
  - out_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Pipeline:
  - Stage k (0..STAGES-1) adds slice k of the operands plus the carry registered by stage k−1; stage 0 uses c_eff.
  - Each stage registers: its valid bit, completed lower slices, pending upper operand slices, and its carry.
  - Flags are computed from the final-stage register contents (combinational from output registers allowed).
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready.
  - in_ready = !valid[0] || advance[0]. Bubbles collapse, so STAGES results can be in flight.
  - Latency is exactly STAGES cycles from accept to out_valid with no backpressure. Throughput is 1 op/cycle.
  - While out_valid && !out_ready, out_sum and all flags are held stable. No item is dropped or duplicated.
  - Inputs are sampled only on accept; changes while in_ready = 0 are ignored.
  - Accept and output transfer in the same cycle with a full pipeline: both occur, occupancy unchanged.
- Reset:
  - Asynchronous assertion clears all valid bits: out_valid = 0, in_ready = 1 after release.
  - out_sum = 0, out_cout = 0, out_ovf = 0, out_neg = 0. out_zero follows out_sum, so it reads 1.
  - Reset mid-operation discards all in-flight ops. The first op accepted after release has full STAGES latency.
- Width boundaries: the carry crosses every slice boundary correctly, e.g. all-ones + 1 ripples through every stage. STAGES = 1 gives a single registered adder with latency 1.

Test Plan:
- WIDTH=32, STAGES=2, add 0xFFFF_FFFF + 0x0000_0001, cin=0 -> 2 cycles later out_sum=0, cout=1, zero=1, ovf=0, neg=0.
- Sub 0x8000_0000 − 0x0000_0001, cin=0 -> out_sum=0x7FFF_FFFF, cout=1, ovf=1, neg=0. Sub 0x5 − 0x7 -> 0xFFFF_FFFE, cout=0, neg=1.
- Add 0x7FFF_FFFF + 0 with cin=1 -> out_sum=0x8000_0000, ovf=1, neg=1. Sub 0x10 − 0x10 with cin=1 -> 0xFFFF_FFFF, cout=0.
- Streaming: 100 random back-to-back ops with out_ready=1 -> in_ready stays 1, results in order, each exactly 2 cycles after accept, match the reference model.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> accepts stop after pipeline fills (2 items), outputs stay stable, no loss or reordering after release.
- Assert rst_n low mid-stream with 2 ops in flight -> out_valid=0 immediately, out_sum=0. After release, the first new op appears after 2 cycles. Repeat with WIDTH=64, STAGES=4 and WIDTH=8, STAGES=1.
